bp_cce_lce_cmd_arbiter: RTL and testbench
=========================================

// Module: bp_cce_lce_cmd_arbiter
// PURPOSE
// - Shares the single CCE->LCE command output between two sources: microcode (ucode) and message unit (msg).
// - Locks the port for the full multi-beat message: header beat through the last data beat.
// - Drives msg_lce_cmd_busy_o into the CCE stall unit, so ucode LCE-command sends stall while msg owns or wins the port.
// - Sits between bp_cce_inst_decode/msg unit and the lce_cmd output stream.
// PARAMETERS
// - data_width_p   128  width of one command beat (header or data)
// - starve_limit_p 4    consecutive lost ucode cycles before ucode is forced to win
// - stat_width_p   32   width of beat counters (only with BP_CCE_LCE_CMD_ARB_STATS_EN)
// PORTS
// - clk_i              in  1              clock; single clock domain
// - reset_n_i          in  1              asynchronous, active-low reset
// - ucode_v_i          in  1              ucode beat valid
// - ucode_data_i       in  data_width_p   ucode beat
// - ucode_last_i       in  1              ucode beat is last of message
// - ucode_ready_and_o  out 1              ucode beat accepted (ready&valid)
// - msg_v_i            in  1              msg unit beat valid
// - msg_data_i         in  data_width_p   msg unit beat
// - msg_last_i         in  1              msg beat is last of message
// - msg_ready_and_o    out 1              msg beat accepted
// - lce_cmd_v_o        out 1              output beat valid
// - lce_cmd_data_o     out data_width_p   output beat
// - lce_cmd_last_o     out 1              output last flag
// - lce_cmd_ready_and_i in 1              downstream ready
// - msg_lce_cmd_busy_o out 1              to stall unit: msg owns or is granted the port
// - ucode_beats_o      out stat_width_p   accepted ucode beats (STATS_EN only)
// - msg_beats_o        out stat_width_p   accepted msg beats (STATS_EN only)
// BEHAVIOUR
// - FSM states: e_arb_idle, e_arb_lock_ucode, e_arb_lock_msg. Reset (reset_n_i=0, async): state=e_arb_idle, starve_cnt=0, counters=0.
// - Datapath is zero-latency and combinational: lce_cmd_{v,data,last}_o = the granted source's inputs.
//   - Grantee ready_and_o = lce_cmd_ready_and_i; non-grantee ready_and_o = 0.
// - Grant in e_arb_idle:
//   - Only one source valid: that source is granted.
//   - Both valid: msg is granted, unless starve_cnt==starve_limit_p, in which case ucode is granted.
//   - Neither valid: lce_cmd_v_o=0, no grant.
// - Transitions out of e_arb_idle:
//   - Handshake of a beat with last=0: go to e_arb_lock_<grantee>.
//   - Handshake with last=1 (single-beat message): stay in e_arb_idle.
//   - No handshake: stay in e_arb_idle, with no lock and no memory of the grant.
// - e_arb_lock_X: source X is granted unconditionally. Handshake with last=1 returns to e_arb_idle; otherwise the lock holds.
// - starve_cnt (saturating at starve_limit_p):
//   - Increments each cycle ucode_v_i=1 with no ucode handshake.
//   - Clears on any ucode handshake.
//   - Holds when ucode_v_i=0.
// - msg_lce_cmd_busy_o = (state==e_arb_lock_msg) | (state==e_arb_idle & msg granted). Combinational, so the stall unit sees it in the same cycle. It is 0 while idle with msg_v_i=0.
// - Sources hold v and data stable until handshake and never drop v mid-message; violating either is an assertion error.
// - Downstream back-pressure (ready=0) during a lock holds the lock indefinitely, with no timeout.
// - Reset asserted mid-message: returns to e_arb_idle immediately, and the partial message is abandoned; the sources are reset in the same domain.
// CONFIGURATION
// - BP_CCE_LCE_CMD_ARB_STATS_EN defined:
//   - ucode_beats_o and msg_beats_o count accepted beats per source and wrap modulo 2^stat_width_p.
//   - Both clear on reset.
// - BP_CCE_LCE_CMD_ARB_STATS_EN undefined: both outputs are tied to 0 and no counter flops exist.
// STRUCTURE
// - bp_me_pkg: typedef enum logic [1:0] bp_cce_lce_cmd_arb_state_e {e_arb_idle, e_arb_lock_ucode, e_arb_lock_msg}.
// - Sub-module: bp_cce_sat_counter (width, max, inc/clr, async active-low reset), instantiated for starve_cnt.
// - FSM, grant mux and optional stats counters are inline.
// TESTING
// - Single-beat ucode (v=1, last=1, data=0xA5) with ready=1 and msg idle -> lce_cmd_data_o=0xA5, ucode_ready_and_o=1, state stays idle.
// - Both assert a 3-beat message in cycle 0 with ready=1:
//   - Msg beats appear in cycles 0-2, msg_lce_cmd_busy_o=1 in cycles 0-2.
//   - Ucode beats appear in cycles 3-5, busy=0 in cycles 3-5.
// - Msg sends back-to-back single beats and ucode stays valid, starve_limit_p=4 -> ucode granted in cycle 4 and starve_cnt returns to 0.
// - Ready=0 for 5 cycles after msg header (last=0) while ucode is valid -> the lock holds, no ucode grant, and after ready=1 the msg data beat completes first.
// - reset_n_i pulsed low mid-lock (after beat 1 of 3) -> all outputs 0 asynchronously, state idle, a new ucode beat is granted after release.
// - With STATS_EN: 2 ucode and 3 msg beats accepted -> ucode_beats_o=2, msg_beats_o=3. Without STATS_EN: both read 0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types for the CCE LCE-command arbiter: FSM state encoding.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_arb_idle       = 2'd0,
    e_arb_lock_ucode = 2'd1,
    e_arb_lock_msg   = 2'd2
  } bp_cce_lce_cmd_arb_state_e;

endpackage

// File: rtl/bp_cce_lce_cmd_arbiter_chk.sv
// Protocol checks on the two sources feeding the LCE-command arbiter.
module bp_cce_lce_cmd_arbiter_chk
  import bp_me_pkg::*;
#(
  parameter int data_width_p = 128
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  input logic                      ucode_v_i,
  input logic [data_width_p-1:0]   ucode_data_i,
  input logic                      ucode_last_i,
  input logic                      ucode_ready_and_i,
  input logic                      msg_v_i,
  input logic [data_width_p-1:0]   msg_data_i,
  input logic                      msg_last_i,
  input logic                      msg_ready_and_i,
  input bp_cce_lce_cmd_arb_state_e state_i
);

  // An offered beat must stay valid and unchanged until it is accepted
  a_ucode_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (ucode_v_i && !ucode_ready_and_i) |=> (ucode_v_i && $stable({ucode_data_i, ucode_last_i})))
    else $error("ucode source changed or dropped an unaccepted beat");

  a_msg_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (msg_v_i && !msg_ready_and_i) |=> (msg_v_i && $stable({msg_data_i, msg_last_i})))
    else $error("msg source changed or dropped an unaccepted beat");

  a_ucode_no_gap: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_i == e_arb_lock_ucode) |-> ucode_v_i)
    else $error("ucode source dropped valid mid-message");

  a_msg_no_gap: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_i == e_arb_lock_msg) |-> msg_v_i)
    else $error("msg source dropped valid mid-message");

endmodule

// File: rtl/bp_cce_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module bp_cce_sat_counter #(
  parameter int width_p = 3,
  parameter int max_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  logic [width_p-1:0] count_q, count_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {width_p{1'b0}};
    end else if (inc_i && (count_q != max_lp)) begin
      count_d = count_q + width_p'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= {width_p{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_cce_lce_cmd_arbiter.sv
// Arbitrates the CCE->LCE command port between ucode and the msg unit with per-message locking.
// Define BP_CCE_LCE_CMD_ARB_STATS_EN to build the per-source accepted-beat counters.
module bp_cce_lce_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int data_width_p   = 128,
  parameter int starve_limit_p = 4,
  parameter int stat_width_p   = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    ucode_v_i,
  input  logic [data_width_p-1:0] ucode_data_i,
  input  logic                    ucode_last_i,
  output logic                    ucode_ready_and_o,
  input  logic                    msg_v_i,
  input  logic [data_width_p-1:0] msg_data_i,
  input  logic                    msg_last_i,
  output logic                    msg_ready_and_o,
  output logic                    lce_cmd_v_o,
  output logic [data_width_p-1:0] lce_cmd_data_o,
  output logic                    lce_cmd_last_o,
  input  logic                    lce_cmd_ready_and_i,
  output logic                    msg_lce_cmd_busy_o,
  output logic [stat_width_p-1:0] ucode_beats_o,
  output logic [stat_width_p-1:0] msg_beats_o
);

  localparam int starve_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(starve_limit_p);

  bp_cce_lce_cmd_arb_state_e   state_q, state_d;
  logic                        grant_ucode_s, grant_msg_s;
  logic                        ucode_hs_s, msg_hs_s;
  logic [starve_width_lp-1:0]  starve_cnt_s;

  // Grant selection; msg is preferred in idle unless ucode has starved
  always_comb begin
    grant_ucode_s = 1'b0;
    grant_msg_s   = 1'b0;
    case (state_q)
      e_arb_idle: begin
        if (ucode_v_i && msg_v_i) begin
          if (starve_cnt_s == starve_max_lp) begin
            grant_ucode_s = 1'b1;
          end else begin
            grant_msg_s = 1'b1;
          end
        end else if (ucode_v_i) begin
          grant_ucode_s = 1'b1;
        end else if (msg_v_i) begin
          grant_msg_s = 1'b1;
        end else begin
          grant_ucode_s = 1'b0;
          grant_msg_s   = 1'b0;
        end
      end
      e_arb_lock_ucode: grant_ucode_s = 1'b1;
      e_arb_lock_msg:   grant_msg_s   = 1'b1;
      default: begin
        grant_ucode_s = 1'b0;
        grant_msg_s   = 1'b0;
      end
    endcase
  end

  // Zero-latency grant mux; everything is forced quiet while reset is held
  always_comb begin
    lce_cmd_v_o       = 1'b0;
    lce_cmd_data_o    = {data_width_p{1'b0}};
    lce_cmd_last_o    = 1'b0;
    ucode_ready_and_o = 1'b0;
    msg_ready_and_o   = 1'b0;
    if (reset_n_i && grant_ucode_s) begin
      lce_cmd_v_o       = ucode_v_i;
      lce_cmd_data_o    = ucode_data_i;
      lce_cmd_last_o    = ucode_last_i;
      ucode_ready_and_o = lce_cmd_ready_and_i;
    end else if (reset_n_i && grant_msg_s) begin
      lce_cmd_v_o     = msg_v_i;
      lce_cmd_data_o  = msg_data_i;
      lce_cmd_last_o  = msg_last_i;
      msg_ready_and_o = lce_cmd_ready_and_i;
    end else begin
      lce_cmd_v_o = 1'b0;
    end
  end

  assign ucode_hs_s         = ucode_v_i & ucode_ready_and_o;
  assign msg_hs_s           = msg_v_i & msg_ready_and_o;
  assign msg_lce_cmd_busy_o = reset_n_i & grant_msg_s;

  // Lock on a non-last beat, release on the last beat of the owner
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_arb_idle: begin
        if (ucode_hs_s && !ucode_last_i) begin
          state_d = e_arb_lock_ucode;
        end else if (msg_hs_s && !msg_last_i) begin
          state_d = e_arb_lock_msg;
        end else begin
          state_d = e_arb_idle;
        end
      end
      e_arb_lock_ucode: begin
        if (ucode_hs_s && ucode_last_i) begin
          state_d = e_arb_idle;
        end else begin
          state_d = e_arb_lock_ucode;
        end
      end
      e_arb_lock_msg: begin
        if (msg_hs_s && msg_last_i) begin
          state_d = e_arb_idle;
        end else begin
          state_d = e_arb_lock_msg;
        end
      end
      default: state_d = e_arb_idle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_arb_idle;
    end else begin
      state_q <= state_d;
    end
  end

  bp_cce_sat_counter #(
    .width_p (starve_width_lp),
    .max_p   (starve_limit_p)
  ) u_starve_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (ucode_hs_s),
    .inc_i     (ucode_v_i & ~ucode_hs_s),
    .count_o   (starve_cnt_s)
  );

`ifdef BP_CCE_LCE_CMD_ARB_STATS_EN
  logic [stat_width_p-1:0] ucode_beats_q, ucode_beats_d;
  logic [stat_width_p-1:0] msg_beats_q, msg_beats_d;

  // Wrapping accepted-beat counters
  always_comb begin
    ucode_beats_d = ucode_beats_q;
    msg_beats_d   = msg_beats_q;
    if (ucode_hs_s) begin
      ucode_beats_d = ucode_beats_q + stat_width_p'(1);
    end else begin
      ucode_beats_d = ucode_beats_q;
    end
    if (msg_hs_s) begin
      msg_beats_d = msg_beats_q + stat_width_p'(1);
    end else begin
      msg_beats_d = msg_beats_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ucode_beats_q <= {stat_width_p{1'b0}};
      msg_beats_q   <= {stat_width_p{1'b0}};
    end else begin
      ucode_beats_q <= ucode_beats_d;
      msg_beats_q   <= msg_beats_d;
    end
  end

  assign ucode_beats_o = ucode_beats_q;
  assign msg_beats_o   = msg_beats_q;
`else
  assign ucode_beats_o = {stat_width_p{1'b0}};
  assign msg_beats_o   = {stat_width_p{1'b0}};
`endif

  bp_cce_lce_cmd_arbiter_chk #(
    .data_width_p (data_width_p)
  ) u_chk (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .ucode_v_i         (ucode_v_i),
    .ucode_data_i      (ucode_data_i),
    .ucode_last_i      (ucode_last_i),
    .ucode_ready_and_i (ucode_ready_and_o),
    .msg_v_i           (msg_v_i),
    .msg_data_i        (msg_data_i),
    .msg_last_i        (msg_last_i),
    .msg_ready_and_i   (msg_ready_and_o),
    .state_i           (state_q)
  );

endmodule

// File: tb/tb_bp_cce_lce_cmd_arbiter.sv
// Directed table-driven bench for bp_cce_lce_cmd_arbiter plus reset and stats sequences.
module tb_bp_cce_lce_cmd_arbiter;

  localparam int DW = 128;
  localparam int SW = 32;
`ifdef BP_CCE_LCE_CMD_ARB_STATS_EN
  localparam bit stats_lp = 1'b1;
`else
  localparam bit stats_lp = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          ucode_v_i, ucode_last_i, ucode_ready_and_o;
  logic [DW-1:0] ucode_data_i;
  logic          msg_v_i, msg_last_i, msg_ready_and_o;
  logic [DW-1:0] msg_data_i;
  logic          lce_cmd_v_o, lce_cmd_last_o, lce_cmd_ready_and_i;
  logic [DW-1:0] lce_cmd_data_o;
  logic          msg_lce_cmd_busy_o;
  logic [SW-1:0] ucode_beats_o, msg_beats_o;

  always #5 clk_i = ~clk_i;

  bp_cce_lce_cmd_arbiter #(
    .data_width_p   (DW),
    .starve_limit_p (4),
    .stat_width_p   (SW)
  ) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .ucode_v_i           (ucode_v_i),
    .ucode_data_i        (ucode_data_i),
    .ucode_last_i        (ucode_last_i),
    .ucode_ready_and_o   (ucode_ready_and_o),
    .msg_v_i             (msg_v_i),
    .msg_data_i          (msg_data_i),
    .msg_last_i          (msg_last_i),
    .msg_ready_and_o     (msg_ready_and_o),
    .lce_cmd_v_o         (lce_cmd_v_o),
    .lce_cmd_data_o      (lce_cmd_data_o),
    .lce_cmd_last_o      (lce_cmd_last_o),
    .lce_cmd_ready_and_i (lce_cmd_ready_and_i),
    .msg_lce_cmd_busy_o  (msg_lce_cmd_busy_o),
    .ucode_beats_o       (ucode_beats_o),
    .msg_beats_o         (msg_beats_o)
  );

  typedef struct {
    string         name;
    logic          uv;
    logic [DW-1:0] ud;
    logic          ul;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          eur;
    logic          emr;
    logic          eb;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // 16-bit tags are replicated across the full beat so every data bit is exercised
  function automatic vec_t mk(string name, logic uv, logic [15:0] ud, logic ul,
                              logic mv, logic [15:0] md, logic ml, logic rdy,
                              logic ev, logic [15:0] ed, logic el,
                              logic eur, logic emr, logic eb);
    vec_t v;
    v.name = name; v.uv = uv; v.ud = {8{ud}}; v.ul = ul;
    v.mv = mv; v.md = {8{md}}; v.ml = ml; v.rdy = rdy;
    v.ev = ev; v.ed = {8{ed}}; v.el = el; v.eur = eur; v.emr = emr; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ucode_v_i = v.uv; ucode_data_i = v.ud; ucode_last_i = v.ul;
    msg_v_i = v.mv; msg_data_i = v.md; msg_last_i = v.ml;
    lce_cmd_ready_and_i = v.rdy;
  endtask

  task automatic check_vec(input vec_t v);
    logic ok;
    n_tests++;
    ok = (lce_cmd_v_o === v.ev) && (ucode_ready_and_o === v.eur) &&
         (msg_ready_and_o === v.emr) && (msg_lce_cmd_busy_o === v.eb) &&
         (!v.ev || ((lce_cmd_data_o === v.ed) && (lce_cmd_last_o === v.el)));
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got v=%0b last=%0b urdy=%0b mrdy=%0b busy=%0b data=%h ; want v=%0b last=%0b urdy=%0b mrdy=%0b busy=%0b data=%h",
               v.name, lce_cmd_v_o, lce_cmd_last_o, ucode_ready_and_o, msg_ready_and_o,
               msg_lce_cmd_busy_o, lce_cmd_data_o, v.ev, v.el, v.eur, v.emr, v.eb, v.ed);
    end
  endtask

  task automatic check_val(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    // Reset state: outputs quiet even with a source offering a beat
    reset_n_i = 1'b0;
    drive(mk("rst", 1'b1, 16'hAA, 1'b1, 1'b1, 16'hBB, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    #2;
    check_vec(mk("reset_outputs", 1'b1, 16'hAA, 1'b1, 1'b1, 16'hBB, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    check_val("reset_ucode_beats", ucode_beats_o, 32'd0);
    check_val("reset_msg_beats", msg_beats_o, 32'd0);
    drive(mk("quiet", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    //                 name               uv   ud       ul    mv   md       ml    rdy   ev   ed       el    eur   emr   busy
    vecs.push_back(mk("single_ucode",     1'b1, 16'hA5,  1'b1, 1'b0, 16'h0,   1'b0, 1'b1, 1'b1, 16'hA5,  1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("idle_gap",         1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   1'b0, 1'b1, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("single_msg",       1'b0, 16'h0,   1'b0, 1'b1, 16'h11,  1'b1, 1'b1, 1'b1, 16'h11,  1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("b0_msg_hdr",       1'b1, 16'h100, 1'b0, 1'b1, 16'h200, 1'b0, 1'b1, 1'b1, 16'h200, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("b1_msg_data",      1'b1, 16'h100, 1'b0, 1'b1, 16'h201, 1'b0, 1'b1, 1'b1, 16'h201, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("b2_msg_last",      1'b1, 16'h100, 1'b0, 1'b1, 16'h202, 1'b1, 1'b1, 1'b1, 16'h202, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("b3_ucode_hdr",     1'b1, 16'h100, 1'b0, 1'b0, 16'h0,   1'b0, 1'b1, 1'b1, 16'h100, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("b4_ucode_lock",    1'b1, 16'h101, 1'b0, 1'b1, 16'h300, 1'b1, 1'b1, 1'b1, 16'h101, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("b5_ucode_last",    1'b1, 16'h102, 1'b1, 1'b1, 16'h300, 1'b1, 1'b1, 1'b1, 16'h102, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("b6_msg_after",     1'b0, 16'h0,   1'b0, 1'b1, 16'h300, 1'b1, 1'b1, 1'b1, 16'h300, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("b7_idle",          1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   1'b0, 1'b1, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk("c_msg_wins",     1'b1, 16'hC0,  1'b1, 1'b1, 16'h400 + 16'(i), 1'b1, 1'b1,
                        1'b1, 16'h400 + 16'(i), 1'b1, 1'b0, 1'b1, 1'b1));
    end
    vecs.push_back(mk("c4_starved_ucode", 1'b1, 16'hC0,  1'b1, 1'b1, 16'h404, 1'b1, 1'b1, 1'b1, 16'hC0,  1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("c5_starve_clear",  1'b1, 16'hC1,  1'b1, 1'b1, 16'h404, 1'b1, 1'b1, 1'b1, 16'h404, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("c6_ucode_alone",   1'b1, 16'hC1,  1'b1, 1'b0, 16'h0,   1'b0, 1'b1, 1'b1, 16'hC1,  1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("c7_idle",          1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   1'b0, 1'b1, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("d0_msg_hdr",       1'b1, 16'hD0,  1'b1, 1'b1, 16'h500, 1'b0, 1'b1, 1'b1, 16'h500, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk("d_backpressure", 1'b1, 16'hD0,  1'b1, 1'b1, 16'h501, 1'b1, 1'b0, 1'b1, 16'h501, 1'b1, 1'b0, 1'b0, 1'b1));
    end
    vecs.push_back(mk("d6_msg_data",      1'b1, 16'hD0,  1'b1, 1'b1, 16'h501, 1'b1, 1'b1, 1'b1, 16'h501, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("d7_starved_ucode", 1'b1, 16'hD0,  1'b1, 1'b1, 16'h502, 1'b1, 1'b1, 1'b1, 16'hD0,  1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk("d8_msg",           1'b0, 16'h0,   1'b0, 1'b1, 16'h502, 1'b1, 1'b1, 1'b1, 16'h502, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk("d9_idle",          1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   1'b0, 1'b1, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      drive(vecs[i]);
      @(negedge clk_i);
      check_vec(vecs[i]);
    end

    // Reset asserted mid-lock, after the header of a 3-beat msg message
    @(posedge clk_i); #1;
    drive(mk("r0", 1'b1, 16'hE0, 1'b1, 1'b1, 16'h600, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk_i);
    check_vec(mk("r0_msg_hdr", 1'b1, 16'hE0, 1'b1, 1'b1, 16'h600, 1'b0, 1'b1, 1'b1, 16'h600, 1'b0, 1'b0, 1'b1, 1'b1));
    @(posedge clk_i); #1;
    msg_data_i = {8{16'h601}};
    #1;
    reset_n_i = 1'b0;
    #1;
    check_vec(mk("r1_outputs_in_reset", 1'b1, 16'hE0, 1'b1, 1'b1, 16'h601, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    check_val("r1_ucode_beats_in_reset", ucode_beats_o, 32'd0);
    ucode_v_i = 1'b0;
    msg_v_i   = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    drive(mk("r2", 1'b1, 16'hE1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk_i);
    check_vec(mk("r2_ucode_after_reset", 1'b1, 16'hE1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'hE1, 1'b1, 1'b1, 1'b0, 1'b0));

    // Stats: one ucode beat accepted above, so the reset below must clear it
    @(posedge clk_i); #1;
    drive(mk("s_quiet", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk_i);
    check_val("s_ucode_beats_before", ucode_beats_o, stats_lp ? 32'd1 : 32'd0);
    reset_n_i = 1'b0;
    #1;
    check_val("s_ucode_beats_cleared", ucode_beats_o, 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      if (i < 2) begin
        drive(mk("s_u", 1'b1, 16'hF0 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
        drive(mk("s_m", 1'b0, 16'h0, 1'b0, 1'b1, 16'hF8 + 16'(i), 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
    @(posedge clk_i); #1;
    drive(mk("s_end", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk_i);
    check_val("s_ucode_beats", ucode_beats_o, stats_lp ? 32'd2 : 32'd0);
    check_val("s_msg_beats", msg_beats_o, stats_lp ? 32'd3 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
